// File: rtl/in_service_8259a_pkg.sv
// ----------------------------------------------------------------------------
// in_service_8259a_pkg
// Shared types and helpers for the 8259A in-service control slice.
//   isc_state_t        : acknowledge FSM state (ST_IDLE, ST_ACK1, ST_ACK2)
//   first_one_t        : {valid, index} result of a first-one search
//   SPURIOUS_LEVEL     : level reported when nothing is pending at first INTA
//   rotate_right8/left8: 8-bit circular rotates by a 3-bit amount
//   priority_first_one : lowest set bit of an 8-bit vector
// ----------------------------------------------------------------------------
package in_service_8259a_pkg;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } isc_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } first_one_t;

    // Bit i of the result is bit (i + amount) mod 8 of the input.
    function automatic logic [7:0] rotate_right8(input logic [7:0] value,
                                                 input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[7:0];
    endfunction

    // Bit (i + amount) mod 8 of the result is bit i of the input.
    function automatic logic [7:0] rotate_left8(input logic [7:0] value,
                                                input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} << amount;
        return doubled[15:8];
    endfunction

    // Lowest set bit wins; valid = 0 when the vector is empty.
    function automatic first_one_t priority_first_one(input logic [7:0] value);
        first_one_t result;
        result = '0;
        for (int i = 7; i >= 0; i--) begin
            if (value[i]) begin
                result.valid = 1'b1;
                result.index = 3'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/in_service_control_8259a_resolver.sv
// ----------------------------------------------------------------------------
// priority_resolver_8259a
// Combinational priority resolution with a rotating base and fully nested
// blocking by the in-service register.
//   candidates    in  8  unmasked pending requests
//   in_service    in  8  current ISR
//   priority_base in  3  level that currently has the highest priority
//   winner_valid  out 1  a candidate outranks every in-service level
//   winner_index  out 3  the winning level
// ----------------------------------------------------------------------------
module priority_resolver_8259a
    import in_service_8259a_pkg::*;
(
    input  logic [7:0] candidates,
    input  logic [7:0] in_service,
    input  logic [2:0] priority_base,
    output logic       winner_valid,
    output logic [2:0] winner_index
);

    first_one_t req_first;
    first_one_t isr_first;

    // After rotating right by the base, position 0 holds the highest-priority
    // level, so a smaller position means a higher priority.
    always_comb begin
        req_first    = priority_first_one(rotate_right8(candidates, priority_base));
        isr_first    = priority_first_one(rotate_right8(in_service, priority_base));
        winner_valid = req_first.valid &&
                       (!isr_first.valid || (req_first.index < isr_first.index));
        // Rotate the chosen position back to an absolute level (mod 8 wrap).
        winner_index = req_first.index + priority_base;
    end

endmodule

// File: rtl/in_service_control_8259a.sv
// ----------------------------------------------------------------------------
// in_service_control_8259a
// Mask/priority resolution, INT generation, two-pulse INTA# acknowledge
// sequence and In-Service Register for an 8259A-compatible controller.
// Configuration macro: ROTATION_EN (rotating priority via rotate_on_eoi);
// when undefined priority is fixed with IR0 highest.
//   clock, reset                 synchronous active-high reset
//   interrupt_request_register   IRR from the request stage
//   interrupt_mask               IMR, 1 = masked
//   auto_eoi_config              clear ISR bit at second INTA rising edge
//   end_of_interrupt             one-cycle pulse, set bits clear ISR bits
//   rotate_on_eoi                cleared level becomes lowest priority
//   interrupt_acknowledge_n      INTA#, already synchronised
//   interrupt_to_cpu             INT
//   freeze                       holds the IRR during acknowledge
//   clear_interrupt_request      one-hot, one-cycle pulse to the IRR
//   in_service_register          current ISR
//   interrupt_vector_index       acknowledged level
//   vector_valid                 one-cycle pulse at second INTA falling edge
//   debug_state                  FSM state (isc_state_t encoding)
// Handshake: INTA# edges are found by comparing against the previous sample;
// each edge is acted on in the clock that detects it, so the registered
// response is visible one clock later.
// ----------------------------------------------------------------------------
module in_service_control_8259a
    import in_service_8259a_pkg::*;
#(
    parameter int         NUM_LEVELS     = 8,
    parameter logic [2:0] SPURIOUS_LEVEL = in_service_8259a_pkg::SPURIOUS_LEVEL
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_LEVELS-1:0] interrupt_request_register,
    input  logic [NUM_LEVELS-1:0] interrupt_mask,
    input  logic                  auto_eoi_config,
    input  logic [NUM_LEVELS-1:0] end_of_interrupt,
    input  logic                  rotate_on_eoi,
    input  logic                  interrupt_acknowledge_n,
    output logic                  interrupt_to_cpu,
    output logic                  freeze,
    output logic [NUM_LEVELS-1:0] clear_interrupt_request,
    output logic [NUM_LEVELS-1:0] in_service_register,
    output logic [2:0]            interrupt_vector_index,
    output logic                  vector_valid,
    output logic [1:0]            debug_state
);

    isc_state_t            state;
    logic                  inta_prev;
    logic                  spurious;
    logic                  inta_fall;
    logic                  inta_rise;
    logic                  auto_eoi_now;
    logic [2:0]            priority_base;
    logic [NUM_LEVELS-1:0] candidates;
    logic [NUM_LEVELS-1:0] isr_next;
    logic                  winner_valid;
    logic [2:0]            winner_index;

    assign inta_fall    = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise    = ~inta_prev & interrupt_acknowledge_n;
    assign candidates   = interrupt_request_register & ~interrupt_mask;
    assign auto_eoi_now = (state == ST_ACK2) && inta_rise && auto_eoi_config && !spurious;
    assign debug_state  = state;

    priority_resolver_8259a u_resolver (
        .candidates    (candidates),
        .in_service    (in_service_register),
        .priority_base (priority_base),
        .winner_valid  (winner_valid),
        .winner_index  (winner_index)
    );

    // ISR update: EOI first, then auto-EOI, then the acknowledge set so that
    // a set on the same bit as an EOI survives.
    always_comb begin
        isr_next = in_service_register & ~end_of_interrupt;
        if (auto_eoi_now) begin
            isr_next[interrupt_vector_index] = 1'b0;
        end
        if ((state == ST_IDLE) && inta_fall && winner_valid) begin
            isr_next[winner_index] = 1'b1;
        end
    end

`ifdef ROTATION_EN
    logic [2:0] eoi_msb;
    logic [2:0] base_next;

    always_comb begin
        eoi_msb = 3'd0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (end_of_interrupt[i]) begin
                eoi_msb = 3'(i);
            end
        end
        base_next = priority_base;
        if (auto_eoi_now && rotate_on_eoi) begin
            base_next = interrupt_vector_index + 3'd1;
        end
        // An explicit EOI in the same cycle takes precedence.
        if (rotate_on_eoi && (|end_of_interrupt)) begin
            base_next = eoi_msb + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            priority_base <= 3'd0;
        end else begin
            priority_base <= base_next;
        end
    end
`else
    logic unused_rotate_on_eoi;

    assign priority_base        = 3'd0;
    assign unused_rotate_on_eoi = rotate_on_eoi;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= ST_IDLE;
            inta_prev               <= 1'b1;
            spurious                <= 1'b0;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            in_service_register     <= '0;
            interrupt_vector_index  <= 3'd0;
            vector_valid            <= 1'b0;
        end else begin
            inta_prev               <= interrupt_acknowledge_n;
            in_service_register     <= isr_next;
            clear_interrupt_request <= '0;
            vector_valid            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    interrupt_to_cpu <= winner_valid;
                    if (inta_fall) begin
                        interrupt_to_cpu <= 1'b0;
                        freeze           <= 1'b1;
                        state            <= ST_ACK1;
                        if (winner_valid) begin
                            interrupt_vector_index                <= winner_index;
                            clear_interrupt_request[winner_index] <= 1'b1;
                            spurious                              <= 1'b0;
                        end else begin
                            interrupt_vector_index <= SPURIOUS_LEVEL;
                            spurious               <= 1'b1;
                        end
                    end
                end
                ST_ACK1: begin
                    interrupt_to_cpu <= 1'b0;
                    if (inta_fall) begin
                        vector_valid <= 1'b1;
                        state        <= ST_ACK2;
                    end
                end
                ST_ACK2: begin
                    interrupt_to_cpu <= 1'b0;
                    if (inta_rise) begin
                        freeze <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    interrupt_to_cpu <= 1'b0;
                    freeze           <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
